// File: rtl/sram_writer_pkg.sv
// Shared definitions for the SRAM score writer: score locations, bus timing
// defaults (common with the address listener) and the FSM state encodings.
package sram_writer_pkg;

    localparam int          NUM_DIGITS   = 6;
    localparam logic [12:0] BASE_ADDR    = 13'h1148;
    localparam logic [12:0] LAST_ADDR    = BASE_ADDR + 13'(NUM_DIGITS - 1);

    localparam int IDLE_CYCLES  = 8;
    localparam int SETUP_CYCLES = 2;
    localparam int PULSE_CYCLES = 4;
    localparam int HOLD_CYCLES  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BUS,
        ST_TURN_ON,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_RELEASE,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CYC_IDLE,
        CYC_SETUP,
        CYC_PULSE,
        CYC_HOLD
    } cyc_phase_t;

    function automatic logic is_bcd(input logic [23:0] s);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Digit 0 is the 100k digit (most significant nibble).
    function automatic logic [3:0] bcd_digit(input logic [23:0] s, input logic [2:0] idx);
        logic [3:0] d;
        case (idx)
            3'd0:    d = s[23:20];
            3'd1:    d = s[19:16];
            3'd2:    d = s[15:12];
            3'd3:    d = s[11:8];
            3'd4:    d = s[7:4];
            3'd5:    d = s[3:0];
            default: d = 4'h0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sram_write_cycle.sv
// One timed SRAM write: SETUP (CE low), PULSE (CE and write low), HOLD (both
// high, address/data kept). Chains straight into the next write when loaded.
module sram_write_cycle
    import sram_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        latch,
    input  logic        load,
    input  logic [12:0] addr,
    input  logic [7:0]  data,
    output logic        phase_last,
    output logic        cycle_done,
    output logic [12:0] sram_address,
    output logic [7:0]  sram_data_out,
    output logic        n_ce,
    output logic        n_write
);

    cyc_phase_t phase, phase_nxt;
    logic [2:0] cnt;
    logic [2:0] phase_len;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        phase_len = 3'd1;
        case (phase)
            CYC_SETUP: phase_len = 3'(SETUP_CYCLES);
            CYC_PULSE: phase_len = 3'(PULSE_CYCLES);
            CYC_HOLD:  phase_len = 3'(HOLD_CYCLES);
            default:   phase_len = 3'd1;
        endcase
    end

    assign phase_last = (cnt == phase_len - 3'd1);
    assign cycle_done = (phase == CYC_HOLD) && phase_last;

    always_comb begin
        phase_nxt = phase;
        case (phase)
            CYC_IDLE:  if (load) phase_nxt = CYC_SETUP;
            CYC_SETUP: if (phase_last) phase_nxt = CYC_PULSE;
            CYC_PULSE: if (phase_last) phase_nxt = CYC_HOLD;
            CYC_HOLD:  if (phase_last) phase_nxt = load ? CYC_SETUP : CYC_IDLE;
            default:   phase_nxt = CYC_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase         <= CYC_IDLE;
            cnt           <= 3'd0;
            sram_address  <= 13'd0;
            sram_data_out <= 8'd0;
            n_ce          <= 1'b1;
            n_write       <= 1'b1;
        end else begin
            phase <= phase_nxt;
            cnt   <= (phase_nxt != phase || phase == CYC_IDLE) ? 3'd0 : cnt + 3'd1;
            if (latch || load) begin
                sram_address  <= addr;
                sram_data_out <= data;
            end
            // Strobes follow the phase being entered, so they stay registered.
            n_ce    <= !(phase_nxt == CYC_SETUP || phase_nxt == CYC_PULSE);
            n_write <= !(phase_nxt == CYC_PULSE);
        end
    end

endmodule

// File: rtl/sram_score_writer.sv
// Writes a 6-digit BCD score into SRAM 0x1148..0x114D: waits for an idle CPU
// bus, turns the transceivers to transmit, runs six write cycles, releases.
module sram_score_writer
    import sram_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [23:0] score,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic        sram_n_ce1_in,
    output logic [12:0] sram_address,
    output logic [7:0]  sram_data_out,
    output logic        sram_n_ce1_out,
    output logic        sram_n_write_out,
    output logic        trans_tx_data,
    output logic        trans_tx_sram_address,
    output logic        trans_n_oe
);

    state_t      state, state_nxt;
    logic [3:0]  idle_cnt;
    logic [2:0]  digit_idx;
    logic [2:0]  sel_idx;
    logic [23:0] score_q;
    logic        trans_tx;
    logic        latch, load;
    logic        phase_last, cycle_done;
    logic        start_ok;
    logic        last_digit;
    logic [12:0] digit_addr;
    logic [7:0]  digit_data;

    assign start_ok   = start && is_bcd(score);
    assign last_digit = (digit_idx == 3'(NUM_DIGITS - 1));
    assign digit_addr = BASE_ADDR + {10'd0, sel_idx};
    assign digit_data = {4'h0, bcd_digit(score_q, sel_idx)};

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        load      = 1'b0;
        sel_idx   = digit_idx;
        case (state)
            ST_IDLE:     if (start_ok) state_nxt = ST_WAIT_BUS;
            ST_WAIT_BUS: begin
                if (sram_n_ce1_in && idle_cnt == 4'(IDLE_CYCLES - 1)) begin
                    state_nxt = ST_TURN_ON;
                    latch     = 1'b1;
                end
            end
            ST_TURN_ON: begin
                state_nxt = ST_SETUP;
                load      = 1'b1;
            end
            ST_SETUP:    if (phase_last) state_nxt = ST_PULSE;
            ST_PULSE:    if (phase_last) state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (cycle_done) begin
                    if (last_digit) begin
                        state_nxt = ST_RELEASE;
                    end else begin
                        // Next digit's address/data go out on the same edge CE drops.
                        state_nxt = ST_SETUP;
                        load      = 1'b1;
                        sel_idx   = digit_idx + 3'd1;
                    end
                end
            end
            ST_RELEASE:  state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            idle_cnt  <= 4'd0;
            digit_idx <= 3'd0;
            score_q   <= 24'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            trans_tx  <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != ST_IDLE);
            done     <= (state_nxt == ST_DONE);
            err      <= (state == ST_IDLE) && start && !is_bcd(score);
            trans_tx <= (state_nxt inside {ST_TURN_ON, ST_SETUP, ST_PULSE, ST_HOLD});
            idle_cnt <= (state == ST_WAIT_BUS && sram_n_ce1_in) ? idle_cnt + 4'd1 : 4'd0;
            if (state == ST_IDLE && start) score_q <= score;
            if (state == ST_IDLE)
                digit_idx <= 3'd0;
            else if (state == ST_HOLD && cycle_done && !last_digit)
                digit_idx <= digit_idx + 3'd1;
        end
    end

    assign trans_tx_data         = trans_tx;
    assign trans_tx_sram_address = trans_tx;
    assign trans_n_oe            = 1'b0;

    sram_write_cycle u_cycle (
        .clk          (clk),
        .rstn         (rstn),
        .latch        (latch),
        .load         (load),
        .addr         (digit_addr),
        .data         (digit_data),
        .phase_last   (phase_last),
        .cycle_done   (cycle_done),
        .sram_address (sram_address),
        .sram_data_out(sram_data_out),
        .n_ce         (sram_n_ce1_out),
        .n_write      (sram_n_write_out)
    );

endmodule

// File: tb/tb_sram_score_writer.sv
// Scoreboard bench for sram_score_writer: stimulus predicts writes, edges and
// pulses from the bus rules; an independent monitor pops and compares.
module tb_sram_score_writer;

    localparam int BASE    = 'h1148;
    localparam int SETUP_N = 2;
    localparam int PULSE_N = 4;
    localparam int HOLD_N  = 2;
    localparam int IDLE_N  = 8;
    localparam int DIGIT_N = SETUP_N + PULSE_N + HOLD_N;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start = 1'b0;
    logic [23:0] score = '0;
    logic        sram_n_ce1_in = 1'b1;
    logic        busy, done, err;
    logic [12:0] sram_address;
    logic [7:0]  sram_data_out;
    logic        sram_n_ce1_out, sram_n_write_out;
    logic        trans_tx_data, trans_tx_sram_address, trans_n_oe;

    sram_score_writer dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .start                (start),
        .score                (score),
        .busy                 (busy),
        .done                 (done),
        .err                  (err),
        .sram_n_ce1_in        (sram_n_ce1_in),
        .sram_address         (sram_address),
        .sram_data_out        (sram_data_out),
        .sram_n_ce1_out       (sram_n_ce1_out),
        .sram_n_write_out     (sram_n_write_out),
        .trans_tx_data        (trans_tx_data),
        .trans_tx_sram_address(trans_tx_sram_address),
        .trans_n_oe           (trans_n_oe)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_wr[$];
    int  exp_done[$], exp_err[$], exp_tx_on[$], exp_tx_off[$];
    bit  ce_low[int];
    int  rnd_lo = -1, rnd_hi = -2;

    int  phase = 0, setup_n = 0, pulse_n = 0, hold_n = 0;
    bit  bad = 1'b0;
    bit  prev_ce = 1'b1, prev_tx = 1'b0;
    int  prev_addr = 0, prev_data = 0;
    wr_t mon_w;
    logic [23:0] rs;
    int  rdig;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic wait_edge(input int t);
        while (edge_cnt < t) @(negedge clk);
    endtask

    // Bus rules: bus taken after IDLE_N consecutive high CE samples; then one
    // turn-on cycle, six 8-cycle digit writes, release, done.
    task automatic predict(input logic [23:0] s, input int e0, output int k);
        int run;
        int e;
        wr_t w;
        run = 0;
        e   = e0;
        while (run < IDLE_N) begin
            e++;
            run = ce_low.exists(e) ? 0 : run + 1;
        end
        k = e;
        for (int i = 0; i < 6; i++) begin
            w.addr = BASE + i;
            w.data = int'((s >> (20 - 4 * i)) & 24'hF);
            exp_wr.push_back(w);
        end
        exp_tx_on.push_back(k);
        exp_tx_off.push_back(k + 1 + 6 * DIGIT_N);
        exp_done.push_back(k + 2 + 6 * DIGIT_N);
        rnd_lo = k + 1;
        rnd_hi = k + 6 * DIGIT_N;
    endtask

    task automatic pulse_start(input logic [23:0] s);
        start = 1'b1;
        score = s;
        @(negedge clk);
        start = 1'b0;
        score = 24'($urandom);
    endtask

    task automatic accept_run(input logic [23:0] s, input int low1, input int low2, input bit restart);
        int e0;
        int k;
        e0 = edge_cnt + 1;
        if (low1 > 0) ce_low[e0 + low1] = 1'b1;
        if (low2 > 0) ce_low[e0 + low2] = 1'b1;
        predict(s, e0, k);
        pulse_start(s);
        check("busy_after_start", busy, 1);
        if (restart) begin
            wait_edge(e0 + 19);
            pulse_start(24'h987654);
        end
        wait_edge(k + 2 + 6 * DIGIT_N);
        check("busy_during_done", busy, 1);
        wait_edge(k + 3 + 6 * DIGIT_N);
        check("busy_released", busy, 0);
    endtask

    task automatic reject_run(input logic [23:0] s);
        int e0;
        e0 = edge_cnt + 1;
        exp_err.push_back(e0);
        pulse_start(s);
        check("busy_on_reject", busy, 0);
        wait_edge(e0 + 3);
        check("busy_after_reject", busy, 0);
    endtask

    task automatic finish_write();
        check("setup_cycles", setup_n, SETUP_N);
        check("pulse_cycles", pulse_n, PULSE_N);
        check("hold_cycles", hold_n, HOLD_N);
        check("strobe_safety", int'(bad), 0);
        bad   = 1'b0;
        phase = 0;
    endtask

    task automatic reset_mid_write(input logic [23:0] s);
        int e0;
        int k;
        e0 = edge_cnt + 1;
        predict(s, e0, k);
        pulse_start(s);
        wait_edge(k + 1 + 3 * DIGIT_N + SETUP_N + 1);
        check("pulse_before_reset", sram_n_write_out, 0);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_ce", sram_n_ce1_out, 1);
        check("rst_mid_nwrite", sram_n_write_out, 1);
        check("rst_mid_tx_data", trans_tx_data, 0);
        check("rst_mid_tx_addr", trans_tx_sram_address, 0);
        check("rst_mid_busy", busy, 0);
        exp_wr.delete();
        exp_done.delete();
        exp_tx_off.delete();
        rnd_hi  = -2;
        phase   = 0;
        bad     = 1'b0;
        prev_ce = 1'b1;
        prev_tx = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial forever begin
        @(negedge clk);
        if (ce_low.exists(edge_cnt + 1))
            sram_n_ce1_in = 1'b0;
        else if (edge_cnt + 1 >= rnd_lo && edge_cnt + 1 <= rnd_hi)
            sram_n_ce1_in = 1'($urandom_range(0, 1));
        else
            sram_n_ce1_in = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (rstn) begin
            if (done) begin
                if (exp_done.size() == 0) check("done_unexpected", done, 0);
                else check("done_edge", edge_cnt, exp_done.pop_front());
            end
            if (err) begin
                if (exp_err.size() == 0) check("err_unexpected", err, 0);
                else check("err_edge", edge_cnt, exp_err.pop_front());
            end
            if (trans_tx_data != prev_tx) begin
                check("tx_dir_match", trans_tx_sram_address, trans_tx_data);
                check("n_oe_low", trans_n_oe, 0);
                if (trans_tx_data) begin
                    if (exp_tx_on.size() == 0) check("tx_on_unexpected", trans_tx_data, 0);
                    else check("tx_on_edge", edge_cnt, exp_tx_on.pop_front());
                end else begin
                    if (exp_tx_off.size() == 0) check("tx_off_unexpected", trans_tx_data, 1);
                    else check("tx_off_edge", edge_cnt, exp_tx_off.pop_front());
                end
            end
            if (!sram_n_write_out && sram_n_ce1_out) bad = 1'b1;
            if (!sram_n_ce1_out && !trans_tx_data) bad = 1'b1;
            if (!sram_n_ce1_out && !prev_ce &&
                (int'(sram_address) != prev_addr || int'(sram_data_out) != prev_data)) bad = 1'b1;

            if (phase == 1) begin
                if (!sram_n_write_out) begin
                    pulse_n = 1;
                    phase   = 2;
                end else if (!sram_n_ce1_out) setup_n++;
                else finish_write();
            end else if (phase == 2) begin
                if (!sram_n_write_out) pulse_n++;
                else if (sram_n_ce1_out) begin
                    hold_n = 1;
                    phase  = 3;
                end else finish_write();
            end else if (phase == 3) begin
                if (sram_n_ce1_out && trans_tx_data) hold_n++;
                else finish_write();
            end

            if (phase == 0 && !sram_n_ce1_out && prev_ce) begin
                if (exp_wr.size() == 0) begin
                    check("write_unexpected", sram_n_ce1_out, 1);
                end else begin
                    mon_w = exp_wr.pop_front();
                    check("wr_addr", sram_address, mon_w.addr);
                    check("wr_data", sram_data_out, mon_w.data);
                end
                setup_n = 1;
                pulse_n = 0;
                hold_n  = 0;
                phase   = 1;
            end

            prev_ce   = sram_n_ce1_out;
            prev_tx   = trans_tx_data;
            prev_addr = int'(sram_address);
            prev_data = int'(sram_data_out);
        end
    end

    initial begin
        #1 rstn = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ce", sram_n_ce1_out, 1);
        check("rst_nwrite", sram_n_write_out, 1);
        check("rst_tx_data", trans_tx_data, 0);
        check("rst_tx_addr", trans_tx_sram_address, 0);
        check("rst_n_oe", trans_n_oe, 0);
        check("rst_addr", sram_address, 0);
        check("rst_data", sram_data_out, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        accept_run(24'h030290, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        accept_run(24'h123456, 6, 0, 1'b0);
        repeat (2) @(negedge clk);
        reject_run(24'h0A0000);
        accept_run(24'h555111, 0, 0, 1'b1);
        reset_mid_write(24'h987650);
        accept_run(24'h246813, 0, 0, 1'b0);
        accept_run(24'h999999, 0, 0, 1'b0);
        accept_run(24'h000001, 3, 11, 1'b0);

        for (int t = 0; t < 10; t++) begin
            for (int d = 0; d < 6; d++) rs[4*d +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) begin
                rdig = int'($urandom_range(0, 5));
                rs[4*rdig +: 4] = 4'($urandom_range(10, 15));
                reject_run(rs);
            end else begin
                accept_run(rs, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 12)) : 0,
                           ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 12)) : 0, 1'b0);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("pending_writes", exp_wr.size(), 0);
        check("pending_done", exp_done.size(), 0);
        check("pending_err", exp_err.size(), 0);
        check("pending_tx_on", exp_tx_on.size(), 0);
        check("pending_tx_off", exp_tx_off.size(), 0);
        check("monitor_idle", phase, 0);
        check("strobe_safety_final", int'(bad), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
